ifetch: RTL and testbench

Instruction fetch stage directly downstream of the `pc` register. It consumes the current PC, issues in-order instruction-memory reads, buffers the returned words with their PCs, and presents them to decode over a valid/ready handshake. It also drives the PC register's next-value input every cycle: the reset vector, PC+4, a hold value, or a redirect target. This makes it the sole owner of PC sequencing.

---
 rtl/ifetch_pkg.sv | 11 +
 rtl/ifetch_fifo.sv | 53 +++++
 rtl/ifetch.sv | 90 +++++++++
 tb/tb_ifetch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: widths, constants and the fetch-buffer entry type shared by the fetch stage
package ifetch_pkg;
    localparam int XLEN = 32;
    localparam int INST_W = 32;
    localparam int PC_STEP = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry circular FIFO with flush, used for fetched words and pending PCs
// Ports: clock/reset (async active-low), push/push_data, pop, flush (wins over push/pop),
//        head (oldest entry), count, empty, full.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter type T = fetch_entry_t
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  T                             push_data,
    output T                             head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    T mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock)
        if (push && !flush) mem[wr_ptr] <= push_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);
endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage that sequences the PC, issues in-order imem reads and buffers results for decode
// Ports: clock, reset (async active-low); io_pc in / io_pc_next out to the pc register;
//        io_imem_req_* request channel, io_imem_resp_* response channel (in order, no backpressure);
//        io_redirect_* redirect from later stages; io_inst_* valid/ready output to decode.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [XLEN-1:0]   io_pc,
    output logic [XLEN-1:0]   io_pc_next,
    output logic              io_imem_req_valid,
    input  logic              io_imem_req_ready,
    output logic [XLEN-1:0]   io_imem_req_addr,
    input  logic              io_imem_resp_valid,
    input  logic [INST_W-1:0] io_imem_resp_data,
    input  logic              io_redirect_valid,
    input  logic [XLEN-1:0]   io_redirect_target,
    output logic              io_inst_valid,
    input  logic              io_inst_ready,
    output logic [INST_W-1:0] io_inst_data,
    output logic [XLEN-1:0]   io_inst_pc
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    resp_entry, buf_head;
    logic [XLEN-1:0] pend_pc, target;
    logic [CW-1:0]   buf_count, outstanding, drop;
    logic [CW:0]     in_use;
    logic            buf_empty, buf_full, pend_empty, pend_full;
    logic            req_fire, resp_take, buf_push, buf_pop;

    assign target = io_redirect_target & ~XLEN'(3);
    assign io_imem_req_addr = {io_pc[XLEN-1:2], 2'b00};
    // The pending queue's occupancy is the in-flight request count.
    assign in_use = {1'b0, outstanding} + {1'b0, buf_count};
    // Credit is judged on registered occupancy only, so a same-cycle pop frees nothing.
    assign io_imem_req_valid = reset && !io_redirect_valid && !pend_full && in_use < (CW+1)'(DEPTH);
    assign req_fire = io_imem_req_valid && io_imem_req_ready;
    assign io_pc_next = !reset ? RESET_PC
                      : io_redirect_valid ? target
                      : req_fire ? io_pc + XLEN'(PC_STEP)
                      : io_pc;

    // Responses with nothing in flight (e.g. issued before reset) are ignored.
    assign resp_take  = io_imem_resp_valid && !pend_empty;
    assign buf_push   = resp_take && drop == '0 && !io_redirect_valid && !buf_full;
    assign resp_entry = '{pc: pend_pc, inst: io_imem_resp_data};

    assign io_inst_valid = !buf_empty && !io_redirect_valid;
    assign buf_pop       = io_inst_valid && io_inst_ready;
    assign io_inst_data  = buf_head.inst;
    assign io_inst_pc    = buf_head.pc;

    // On redirect every request still unanswered after this cycle must be discarded.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) drop <= '0;
        else if (io_redirect_valid) drop <= outstanding - CW'(resp_take);
        else if (resp_take && drop != '0) drop <= drop - CW'(1);
    end

    ifetch_fifo #(.DEPTH(DEPTH)) u_buf (
        .clock(clock),
        .reset(reset),
        .push(buf_push),
        .pop(buf_pop),
        .flush(io_redirect_valid),
        .push_data(resp_entry),
        .head(buf_head),
        .count(buf_count),
        .empty(buf_empty),
        .full(buf_full)
    );

    ifetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_pend (
        .clock(clock),
        .reset(reset),
        .push(req_fire),
        .pop(resp_take),
        .flush(1'b0),
        .push_data(io_imem_req_addr),
        .head(pend_pc),
        .count(outstanding),
        .empty(pend_empty),
        .full(pend_full)
    );
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed self-checking bench for ifetch with a pc register and variable-latency memory model
`timescale 1ns/1ps
module tb_ifetch;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clock, reset;
    logic [31:0] io_pc, io_pc_next, io_imem_req_addr, io_imem_resp_data, io_redirect_target;
    logic [31:0] io_inst_data, io_inst_pc;
    logic        io_imem_req_valid, io_imem_req_ready, io_imem_resp_valid, io_redirect_valid;
    logic        io_inst_valid, io_inst_ready;

    logic [31:0] pc_q, pc_ovr, exp_pc;
    logic        pc_ovr_en;
    int          lat, cyc, n_chk, n_fail, ndeliv, nfire;

    typedef struct {
        logic [31:0] a;
        int          due;
    } req_t;
    req_t mq[$];

    typedef struct {
        logic [31:0] pc;
        logic        rv;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] nxt;
        logic        req;
        logic [31:0] addr;
    } vec_t;
    vec_t vt[7];

    ifetch #(.DEPTH(2), .RESET_PC(RST_PC)) dut (
        .clock(clock),
        .reset(reset),
        .io_pc(io_pc),
        .io_pc_next(io_pc_next),
        .io_imem_req_valid(io_imem_req_valid),
        .io_imem_req_ready(io_imem_req_ready),
        .io_imem_req_addr(io_imem_req_addr),
        .io_imem_resp_valid(io_imem_resp_valid),
        .io_imem_resp_data(io_imem_resp_data),
        .io_redirect_valid(io_redirect_valid),
        .io_redirect_target(io_redirect_target),
        .io_inst_valid(io_inst_valid),
        .io_inst_ready(io_inst_ready),
        .io_inst_data(io_inst_data),
        .io_inst_pc(io_inst_pc)
    );

    initial clock = 0;
    always #10 clock = ~clock;

    assign io_pc = pc_ovr_en ? pc_ovr : pc_q;

    initial pc_q = 0;
    always @(posedge clock) pc_q <= io_pc_next;

    initial begin
        cyc = 0;
        io_imem_resp_valid = 0;
        io_imem_resp_data = 0;
    end
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (io_imem_req_valid && io_imem_req_ready) mq.push_back('{io_imem_req_addr, cyc + lat});
        if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
            io_imem_resp_valid <= 1'b1;
            io_imem_resp_data  <= mq[0].a ^ KEY;
            void'(mq.pop_front());
        end else begin
            io_imem_resp_valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        #1;
        if (io_inst_valid && io_inst_ready) begin
            chk("inst_pc", io_inst_pc, exp_pc);
            chk("inst_data", io_inst_data, exp_pc ^ KEY);
            exp_pc += 4;
            ndeliv++;
        end
        if (io_imem_req_valid && io_imem_req_ready) nfire++;
        @(negedge clock);
    endtask

    task automatic drain();
        io_imem_req_ready = 0;
        io_inst_ready = 1;
        repeat (8) step();
    endtask

    task automatic redir(input int l, input int pre, input logic [31:0] tgt, input logic dec,
                         input logic exp_v, input logic exp_r1);
        logic [31:0] t;
        int n0;
        t = {tgt[31:2], 2'b00};
        drain();
        lat = l;
        io_imem_req_ready = 1;
        io_inst_ready = dec;
        repeat (pre) step();
        #1 chk("pre_redir_inst_valid", 32'(io_inst_valid), 32'(exp_v));
        io_redirect_valid = 1;
        io_redirect_target = tgt;
        io_inst_ready = 1;
        #1;
        chk("redir_inst_valid", 32'(io_inst_valid), 0);
        chk("redir_req_valid", 32'(io_imem_req_valid), 0);
        chk("redir_pc_next", io_pc_next, t);
        exp_pc = t;
        step();
        io_redirect_valid = 0;
        #1;
        chk("redir_r1_pc", io_pc, t);
        chk("redir_r1_req_valid", 32'(io_imem_req_valid), 32'(exp_r1));
        chk("redir_r1_addr", io_imem_req_addr, t);
        n0 = ndeliv;
        repeat (12) step();
        chk("redir_delivered", 32'(ndeliv > n0), 1);
    endtask

    initial begin
        int n0;
        logic [31:0] base;
        vt[0] = '{32'h0000_0100, 1'b0, 32'h0, 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100};
        vt[1] = '{32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC};
        vt[2] = '{32'h0000_0123, 1'b0, 32'h0, 1'b1, 32'h0000_0127, 1'b1, 32'h0000_0120};
        vt[3] = '{32'h0000_0100, 1'b0, 32'h0, 1'b0, 32'h0000_0100, 1'b1, 32'h0000_0100};
        vt[4] = '{32'h0000_0100, 1'b1, 32'h0000_0203, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0100};
        vt[5] = '{32'h0000_0040, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0040};
        vt[6] = '{32'h8000_0000, 1'b0, 32'h0, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0000};
        n_chk = 0; n_fail = 0; ndeliv = 0; nfire = 0;
        reset = 0; lat = 1; pc_ovr_en = 0; pc_ovr = 0; exp_pc = RST_PC;
        io_imem_req_ready = 1; io_inst_ready = 1;
        io_redirect_valid = 0; io_redirect_target = 0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_req_valid", 32'(io_imem_req_valid), 0);
        chk("rst_inst_valid", 32'(io_inst_valid), 0);
        chk("rst_pc_next", io_pc_next, RST_PC);
        @(negedge clock);
        reset = 1;
        #1;
        chk("first_req_valid", 32'(io_imem_req_valid), 1);
        chk("first_req_addr", io_imem_req_addr, RST_PC);
        step();
        #1;
        chk("c1_inst_valid", 32'(io_inst_valid), 0);
        chk("c1_req_addr", io_imem_req_addr, RST_PC + 4);
        step();
        #1;
        chk("c2_inst_valid", 32'(io_inst_valid), 1);
        chk("c2_inst_pc", io_inst_pc, RST_PC);
        n0 = ndeliv;
        repeat (12) step();
        chk("stream_count", 32'(ndeliv - n0 >= 8), 1);

        drain();
        pc_ovr_en = 1;
        for (int i = 0; i < 7; i++) begin
            pc_ovr = vt[i].pc;
            io_redirect_valid = vt[i].rv;
            io_redirect_target = vt[i].tgt;
            io_imem_req_ready = vt[i].rdy;
            #1;
            chk("vec_pc_next", io_pc_next, vt[i].nxt);
            chk("vec_req_valid", 32'(io_imem_req_valid), 32'(vt[i].req));
            chk("vec_req_addr", io_imem_req_addr, vt[i].addr);
            chk("vec_inst_valid", 32'(io_inst_valid), 0);
        end
        pc_ovr_en = 0;
        io_redirect_valid = 0;
        io_imem_req_ready = 0;
        step();

        lat = 1;
        io_imem_req_ready = 1;
        io_inst_ready = 0;
        base = exp_pc;
        n0 = nfire;
        repeat (10) step();
        #1;
        chk("stall_fires", 32'(nfire - n0), 2);
        chk("stall_pc_next", io_pc_next, base + 8);
        chk("stall_req_valid", 32'(io_imem_req_valid), 0);
        chk("stall_inst_valid", 32'(io_inst_valid), 1);
        chk("stall_head_pc", io_inst_pc, base);
        io_inst_ready = 1;
        n0 = ndeliv;
        repeat (10) step();
        chk("stall_resume", 32'(ndeliv >= n0 + 2), 1);

        redir(3, 2, 32'h0000_0200, 1'b1, 1'b0, 1'b0);
        redir(3, 3, 32'h0000_0400, 1'b1, 1'b0, 1'b1);
        redir(2, 3, 32'h0000_0303, 1'b0, 1'b1, 1'b1);
        redir(1, 0, 32'hFFFF_FFFB, 1'b1, 1'b0, 1'b1);

        drain();
        lat = 2;
        io_imem_req_ready = 1;
        step();
        io_imem_req_ready = 0;
        reset = 0;
        #1;
        chk("midrst_req_valid", 32'(io_imem_req_valid), 0);
        chk("midrst_inst_valid", 32'(io_inst_valid), 0);
        chk("midrst_pc_next", io_pc_next, RST_PC);
        step();
        reset = 1;
        io_imem_req_ready = 1;
        exp_pc = RST_PC;
        #1;
        chk("postrst_req_valid", 32'(io_imem_req_valid), 1);
        chk("postrst_req_addr", io_imem_req_addr, RST_PC);
        n0 = ndeliv;
        repeat (8) step();
        chk("postrst_delivered", 32'(ndeliv > n0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
